enable_pulse_sync: RTL and testbench
====================================

// Module: enable_pulse_sync
// PURPOSE
//  Destination-domain control stage of the data synchronizer. Synchronizes the
//  source-domain bus enable level through a multi-flop chain and turns each
//  accepted rising edge into a one-cycle select pulse. The select pulse drives
//  the bus-capture mux. A delayed pulse marks the cycle in which the captured bus is valid.
// PARAMETERS
//  NUM_STAGES  2  synchronizer flop count; legal values 2..4
//  MIN_HIGH    3  synced-high cycles required before a pulse; used only with SYNC_FILTER_EN; >=2
//  CNT_WIDTH   8  width of transfer counter
// PORTS
//  CLK           in   1          destination clock
//  RST           in   1          async reset, active-low
//  bus_enable    in   1          unsynchronized enable level from source domain
//  sync_sel      out  1          1-cycle select pulse to capture mux (registered)
//  enable_pulse  out  1          sync_sel delayed 1 cycle; captured bus valid this cycle
//  busy          out  1          FSM not in IDLE
//  xfer_count    out  CNT_WIDTH  count of issued pulses; wraps
// BEHAVIOUR
//  - Reset (RST=0, async): sync chain, sync_sel, enable_pulse, busy, xfer_count,
//    and the filter counter all go to 0; FSM goes to IDLE.
//  - Chain: stage0 <= bus_enable; stage[i] <= stage[i-1]. lvl = stage[NUM_STAGES-1].
//  - The FSM (IDLE, QUAL, HIGH) is the only logic that reads lvl. All outputs are registered.
//  - IDLE: lvl=0 -> stay. lvl=1 -> HIGH, and sync_sel<=1 (no filter).
//    With the filter, lvl=1 -> QUAL and qcnt<=1 instead.
//  - QUAL (filter only): lvl=0 -> IDLE, qcnt<=0 (glitch rejected, no pulse).
//    lvl=1 and qcnt==MIN_HIGH-1 -> HIGH, sync_sel<=1.
//    lvl=1 and qcnt<MIN_HIGH-1 -> qcnt<=qcnt+1.
//  - HIGH: lvl=1 -> stay, no further pulse. lvl=0 -> IDLE.
//  - Pulse width: sync_sel is high for exactly 1 cycle per accepted edge.
//  - Delayed pulse: enable_pulse <= sync_sel.
//  - Counter: xfer_count increments on the edge where enable_pulse<=1.
//    It wraps from 2^CNT_WIDTH-1 to 0.
//  - Latency: bus_enable is sampled high at edge 1.
//    Without the filter, sync_sel is high after edge NUM_STAGES+1.
//    With the filter, sync_sel is high after edge NUM_STAGES+MIN_HIGH.
//    In both cases enable_pulse follows one edge after sync_sel.
//  - Level low-to-high in HIGH: no pulse; a fresh pulse needs lvl to return to 0 (re-arm via IDLE).
//  - The minimum lvl-low time for re-arm is 1 cycle.
//  - busy = (state != IDLE), registered with the state.
//  - Reset mid-operation: everything clears, and any pending pulse is lost.
//    If bus_enable is still high after release, it is treated as a new rising edge
//    and issues exactly one pulse.
//  - Width rules: qcnt is $clog2(MIN_HIGH)+1 bits and never exceeds MIN_HIGH-1.
// CONFIGURATION
//  SYNC_FILTER_EN defined: QUAL state and qcnt are built in.
//    lvl high pulses shorter than MIN_HIGH cycles produce no sync_sel and no count.
//  SYNC_FILTER_EN undefined: QUAL and qcnt are not synthesized.
//    IDLE goes directly to HIGH on lvl=1, and MIN_HIGH is ignored.
// TESTING
//  1. Reset value: hold RST=0 with bus_enable=1 -> all outputs 0, busy=0.
//     Then release RST, no filter, NUM_STAGES=2 -> sync_sel=1 after edge 3 only,
//     and xfer_count=1.
//  2. Single transfer: bus_enable 0->1 held for 10 cycles, no filter ->
//     sync_sel high for 1 cycle, enable_pulse the next cycle, busy until lvl=0.
//  3. Back-to-back: five enable pulses, each 4 cycles high and 2 low ->
//     5 sync_sel pulses, xfer_count=5.
//  4. Filter, MIN_HIGH=3: a 2-cycle enable glitch gives no pulse and a return to IDLE.
//     A 5-cycle enable high gives sync_sel after edge NUM_STAGES+3.
//  5. Wrap: CNT_WIDTH=2, five transfers -> xfer_count goes 1,2,3,0,1.
//  6. Async reset asserted while in HIGH -> outputs 0 immediately with no CLK edge;
//     after release with bus_enable high -> exactly one new pulse.

Source files
------------

// File: rtl/enable_pulse_sync_if.sv
// Interface between the source-side enable driver and the destination-domain
// enable/pulse synchronizer. The master drives the raw enable level. The slave
// (the synchronizer) returns the capture select, the valid pulse, busy and the
// transfer count.
interface enable_pulse_sync_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 bus_enable;
    logic                 sync_sel;
    logic                 enable_pulse;
    logic                 busy;
    logic [CNT_WIDTH-1:0] xfer_count;

    modport master (
        output bus_enable,
        input  sync_sel,
        input  enable_pulse,
        input  busy,
        input  xfer_count
    );

    modport slave (
        input  bus_enable,
        output sync_sel,
        output enable_pulse,
        output busy,
        output xfer_count
    );
endinterface

// File: rtl/enable_pulse_sync.sv
// enable_pulse_sync: destination-domain control stage of the data synchronizer.
// The raw source enable level passes through a NUM_STAGES flop chain. Each
// accepted rising edge of the synchronized level becomes a one-cycle sync_sel
// pulse for the capture mux. enable_pulse follows one cycle later and marks the
// cycle in which the captured bus is valid. xfer_count counts the issued pulses
// and wraps.
//
// Optional feature macro: SYNC_FILTER_EN
//   When defined, the synchronized level must stay high for MIN_HIGH consecutive
//   cycles, tracked in the QUAL state, before a pulse is issued. Shorter highs
//   are treated as glitches.
//   When undefined, QUAL and its qualification counter are not built, and
//   MIN_HIGH serves only the parameter legality check.
module enable_pulse_sync #(
    parameter int NUM_STAGES = 2,
    parameter int MIN_HIGH   = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    enable_pulse_sync_if.slave  bus
);

    // Reject illegal configurations at elaboration time.
    if ((NUM_STAGES < 2) || (NUM_STAGES > 4) || (MIN_HIGH < 2)) begin : g_bad_cfg
        $error("enable_pulse_sync: illegal NUM_STAGES or MIN_HIGH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HIGH = 2'd2
    } state_t;

    logic [NUM_STAGES-1:0] stage_r;
    logic                  lvl_s;
    state_t                state_r;
    state_t                state_next_s;
    logic                  sel_next_s;
    logic                  busy_r;
    logic                  sync_sel_r;
    logic                  enable_pulse_r;
    logic [CNT_WIDTH-1:0]  xfer_count_r;

`ifdef SYNC_FILTER_EN
    localparam int QCNT_W = $clog2(MIN_HIGH) + 1;
    localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(MIN_HIGH - 1);

    logic [QCNT_W-1:0] qcnt_r;
    logic [QCNT_W-1:0] qcnt_next_s;
`endif

    // The synchronized level is the last flop of the chain. Only the FSM reads it.
    assign lvl_s = stage_r[NUM_STAGES-1];

    // Multi-flop synchronizer chain for the asynchronous enable level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stage_r <= {NUM_STAGES{1'b0}};
        end else begin
            stage_r <= {stage_r[NUM_STAGES-2:0], bus.bus_enable};
        end
    end

    // Next-state and pulse decode. A pulse is issued only on entry into HIGH.
    always_comb begin
        state_next_s = state_r;
        sel_next_s   = 1'b0;
`ifdef SYNC_FILTER_EN
        qcnt_next_s  = qcnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (lvl_s) begin
`ifdef SYNC_FILTER_EN
                    state_next_s = QUAL;
                    qcnt_next_s  = QCNT_W'(1);
`else
                    state_next_s = HIGH;
                    sel_next_s   = 1'b1;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef SYNC_FILTER_EN
            QUAL: begin
                if (!lvl_s) begin
                    // The level dropped too early: reject it as a glitch.
                    state_next_s = IDLE;
                    qcnt_next_s  = QCNT_W'(0);
                end else if (qcnt_r == QCNT_LAST) begin
                    state_next_s = HIGH;
                    sel_next_s   = 1'b1;
                    qcnt_next_s  = QCNT_W'(0);
                end else begin
                    qcnt_next_s  = qcnt_r + QCNT_W'(1);
                end
            end
`endif
            HIGH: begin
                if (lvl_s) begin
                    state_next_s = HIGH;
                end else begin
                    // The level must return low before a new pulse can be armed.
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                sel_next_s   = 1'b0;
            end
        endcase
    end

    // State register. busy is registered together with the state it reflects.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

`ifdef SYNC_FILTER_EN
    // Qualification counter for the glitch filter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            qcnt_r <= QCNT_W'(0);
        end else begin
            qcnt_r <= qcnt_next_s;
        end
    end
`endif

    // Select pulse, delayed valid pulse and the wrapping transfer counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_sel_r     <= 1'b0;
            enable_pulse_r <= 1'b0;
            xfer_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            sync_sel_r     <= sel_next_s;
            enable_pulse_r <= sync_sel_r;
            if (sync_sel_r) begin
                xfer_count_r <= xfer_count_r + CNT_WIDTH'(1);
            end else begin
                xfer_count_r <= xfer_count_r;
            end
        end
    end

    assign bus.sync_sel     = sync_sel_r;
    assign bus.enable_pulse = enable_pulse_r;
    assign bus.busy         = busy_r;
    assign bus.xfer_count   = xfer_count_r;

endmodule

// File: tb/tb_enable_pulse_sync.sv
// Self-checking bench for enable_pulse_sync. A run-length model derives every
// output from the delayed enable samples and is compared on each falling clock
// edge. Directed scenarios add hand-computed literal checks. A second instance
// with a 2-bit counter exercises counter wrap. The bench follows SYNC_FILTER_EN.
module tb_enable_pulse_sync;
    localparam int NS = 2;
    localparam int MH = 3;
    localparam int CW = 8;
`ifdef SYNC_FILTER_EN
    localparam int REQ       = MH;
    localparam int GLITCH_EX = 0;
`else
    localparam int REQ       = 1;
    localparam int GLITCH_EX = 1;
`endif
    // Edge number, counted from reset release, at which sync_sel is first high.
    localparam int LAT = NS + REQ;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic be  = 1'b0;

    always #5 CLK = ~CLK;

    enable_pulse_sync_if #(.CNT_WIDTH(CW)) bif ();
    enable_pulse_sync_if #(.CNT_WIDTH(2))  wif ();
    assign bif.bus_enable = be;
    assign wif.bus_enable = be;

    enable_pulse_sync #(.NUM_STAGES(NS), .MIN_HIGH(MH), .CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif)
    );

    enable_pulse_sync #(.NUM_STAGES(NS), .MIN_HIGH(MH), .CNT_WIDTH(2)) dut_wrap (
        .CLK (CLK),
        .RST (RST),
        .bus (wif)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the level seen at a given edge is the enable sample taken NS edges
    // earlier, or 0 while the chain still holds reset zeros. A pulse occurs when
    // the current run of high levels reaches REQ. busy is high while that run
    // is nonzero.
    logic        hist [0:4095];
    int          ecount    = 0;
    int          since_rst = 0;
    int          run       = 0;
    logic        m_lvl;
    int          nrun;
    logic        m_sel     = 1'b0;
    logic        m_pulse   = 1'b0;
    logic        m_busy    = 1'b0;
    int unsigned m_count   = 0;

    always_comb begin
        m_lvl = 1'b0;
        if (since_rst >= NS) m_lvl = hist[(ecount - NS) & 4095];
        nrun = m_lvl ? run + 1 : 0;
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            since_rst <= 0;
            run       <= 0;
            m_sel     <= 1'b0;
            m_pulse   <= 1'b0;
            m_busy    <= 1'b0;
            m_count   <= 0;
        end else begin
            hist[ecount & 4095] <= be;
            ecount    <= ecount + 1;
            since_rst <= since_rst + 1;
            run       <= nrun;
            m_sel     <= (nrun == REQ);
            m_busy    <= (nrun != 0);
            m_pulse   <= m_sel;
            m_count   <= m_count + (m_sel ? 1 : 0);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        check("sync_sel",     {31'd0, bif.sync_sel},     {31'd0, m_sel});
        check("enable_pulse", {31'd0, bif.enable_pulse}, {31'd0, m_pulse});
        check("busy",         {31'd0, bif.busy},         {31'd0, m_busy});
        check("xfer_count",   {24'd0, bif.xfer_count},   m_count % 256);
        check("wrap_count",   {30'd0, wif.xfer_count},   m_count % 4);
    end

    // Monitors for the directed checks.
    int         sel_seen = 0;
    int         wrap_n   = 0;
    logic [1:0] wrap_log [0:63];
    always @(negedge CLK) begin
        if (bif.sync_sel === 1'b1) sel_seen++;
        if (wif.enable_pulse === 1'b1) begin
            wrap_log[wrap_n & 63] = wif.xfer_count;
            wrap_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int         s;
        int         wb;
        logic [1:0] exp_wrap [0:4];
        exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3;
        exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd1;

        // Reset held low with the enable high: every output stays at zero.
        RST = 1'b0;
        be  = 1'b1;
        tick(3);
        check("rst_sel",   {31'd0, bif.sync_sel},     32'd0);
        check("rst_pulse", {31'd0, bif.enable_pulse}, 32'd0);
        check("rst_busy",  {31'd0, bif.busy},         32'd0);
        check("rst_count", {24'd0, bif.xfer_count},   32'd0);

        // Release with the enable high: sync_sel rises only after edge LAT.
        RST = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick(1);
            check("lat_sel", {31'd0, bif.sync_sel}, (e == LAT) ? 32'd1 : 32'd0);
        end
        check("lat_pulse", {31'd0, bif.enable_pulse}, 32'd1);
        check("lat_count", {24'd0, bif.xfer_count},   32'd1);

        // Single transfer: the enable is held high for 10 cycles.
        be = 1'b0;
        tick(6);
        check("idle_busy", {31'd0, bif.busy}, 32'd0);
        s  = sel_seen;
        be = 1'b1;
        tick(10);
        check("hold_busy", {31'd0, bif.busy}, 32'd1);
        be = 1'b0;
        tick(6);
        check("single_pulses", sel_seen - s, 32'd1);
        check("single_busy",   {31'd0, bif.busy},       32'd0);
        check("single_count",  {24'd0, bif.xfer_count}, 32'd2);

        // Five back-to-back transfers after a fresh reset; the 2-bit counter wraps.
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
        s   = sel_seen;
        wb  = wrap_n;
        for (int i = 0; i < 5; i++) begin
            be = 1'b1;
            tick(4);
            be = 1'b0;
            tick(2);
        end
        tick(8);
        check("b2b_pulses", sel_seen - s,             32'd5);
        check("b2b_count",  {24'd0, bif.xfer_count},  32'd5);
        check("wrap_n",     wrap_n - wb,              32'd5);
        for (int i = 0; i < 5; i++) begin
            check("wrap_seq", {30'd0, wrap_log[(wb + i) & 63]}, {30'd0, exp_wrap[i]});
        end

        // A 2-cycle glitch is rejected only when the filter is built in.
        s  = sel_seen;
        be = 1'b1;
        tick(2);
        be = 1'b0;
        tick(8);
        check("glitch_pulses", sel_seen - s,      GLITCH_EX);
        check("glitch_busy",   {31'd0, bif.busy}, 32'd0);
        s  = sel_seen;
        be = 1'b1;
        tick(5);
        be = 1'b0;
        tick(8);
        check("long_pulses", sel_seen - s, 32'd1);

        // Async reset while in HIGH clears outputs without any clock edge.
        be = 1'b1;
        tick(LAT + 3);
        check("pre_rst_busy", {31'd0, bif.busy}, 32'd1);
        RST = 1'b0;
        #1;
        check("arst_sel",   {31'd0, bif.sync_sel},     32'd0);
        check("arst_pulse", {31'd0, bif.enable_pulse}, 32'd0);
        check("arst_busy",  {31'd0, bif.busy},         32'd0);
        check("arst_count", {24'd0, bif.xfer_count},   32'd0);
        tick(2);
        s   = sel_seen;
        RST = 1'b1;
        tick(12);
        check("rearm_pulses", sel_seen - s,            32'd1);
        check("rearm_count",  {24'd0, bif.xfer_count}, 32'd1);
        be = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
